player_motion: RTL

- Generates the player's vertical position `p_vpos` and animation frame `char_frame`, which feed the game-logic collision and render stages.
- Tracks the wave surface height sampled at the player column, supplied by the wave generator via `wave_height` / `wave_ready`.
- Updates once per video frame on a one-cycle `frame_tick` strobe. Motion is rate-limited while surfing and ballistic (gravity) when the wave drops away faster than the player can follow.

---
 rtl/player_motion.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/player_motion.sv
// Player vertical motion: tracks the sampled wave surface once per video frame,
// rate-limited while surfing and ballistic while airborne.
module player_motion #(
    parameter int V_MIN      = 16,
    parameter int V_MAX      = 740,
    parameter int START_VPOS = 384,
    parameter int MAX_STEP   = 4,
    parameter int GRAV       = 1,
    parameter int VEL_MAX    = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [9:0] wave_height,
    input  logic       wave_ready,
    output logic [9:0] p_vpos,
    output logic [1:0] char_frame,
    output logic       airborne,
    output logic       landed,
    output logic [7:0] air_frames
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SURF = 2'd1,
        S_AIR  = 2'd2
    } state_t;

    localparam logic [9:0]         VMIN_L  = 10'(V_MIN);
    localparam logic [9:0]         VMAX_L  = 10'(V_MAX);
    localparam logic [9:0]         START_L = 10'(START_VPOS);
    localparam logic [9:0]         STEP_L  = 10'(MAX_STEP);
    localparam logic signed [10:0] STEP_S  = 11'(MAX_STEP);
    localparam logic [7:0]         STEP8   = 8'(MAX_STEP);
    localparam logic [7:0]         GRAV_L  = 8'(GRAV);
    localparam logic [7:0]         VMAXV_L = 8'(VEL_MAX);

    state_t     r_state, w_state_n;
    logic [9:0] r_p_vpos, w_p_vpos_n;
    logic [1:0] r_char_frame, w_char_frame_n;
    logic       r_landed, w_landed_n;
    logic [7:0] r_air_frames, w_air_frames_n;
    logic [9:0] r_target, w_target_n;
    logic       r_target_valid, w_target_valid_n;
    logic [7:0] r_vel, w_vel_n;
    logic [7:0] r_air_cnt, w_air_cnt_n;

    logic signed [10:0] w_diff;
    logic [9:0]         w_clamped;
    logic [7:0]         w_vel_inc;
    logic [7:0]         w_vel_nx;
    logic [10:0]        w_sum;
    logic [7:0]         w_cnt_inc;

    assign w_clamped = (wave_height < VMIN_L) ? VMIN_L :
                       (wave_height > VMAX_L) ? VMAX_L : wave_height;
    assign w_diff    = $signed({1'b0, r_target}) - $signed({1'b0, r_p_vpos});
    assign w_vel_inc = r_vel + GRAV_L;
    assign w_vel_nx  = (w_vel_inc > VMAXV_L) ? VMAXV_L : w_vel_inc;
    assign w_sum     = {1'b0, r_p_vpos} + {3'b000, w_vel_nx};
    assign w_cnt_inc = (r_air_cnt == 8'hFF) ? 8'hFF : r_air_cnt + 8'd1;

    // NOTE: every next-state variable gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_n        = r_state;
        w_p_vpos_n       = r_p_vpos;
        w_char_frame_n   = r_char_frame;
        w_landed_n       = 1'b0;
        w_air_frames_n   = r_air_frames;
        w_vel_n          = r_vel;
        w_air_cnt_n      = r_air_cnt;
        w_target_n       = wave_ready ? w_clamped : r_target;
        w_target_valid_n = wave_ready | r_target_valid;

        if (!enable) begin
            w_state_n        = S_IDLE;
            w_p_vpos_n       = START_L;
            w_char_frame_n   = 2'd0;
            w_vel_n          = 8'd0;
            w_air_cnt_n      = 8'd0;
            w_target_valid_n = 1'b0;
        end else if (frame_tick) begin
            // The frame update always sees the target latched before this cycle.
            unique case (r_state)
                S_IDLE: begin
                    if (r_target_valid) begin
                        w_state_n      = S_SURF;
                        w_p_vpos_n     = START_L;
                        w_char_frame_n = 2'd0;
                    end
                end
                S_SURF: begin
                    if (w_diff > STEP_S) begin
                        w_p_vpos_n     = r_p_vpos + STEP_L;
                        w_vel_n        = STEP8;
                        w_air_cnt_n    = 8'd1;
                        w_state_n      = S_AIR;
                        w_char_frame_n = 2'd2;
                    end else if (w_diff > 11'sd0) begin
                        w_p_vpos_n     = r_target;
                        w_char_frame_n = 2'd2;
                    end else if (w_diff == 11'sd0) begin
                        w_char_frame_n = 2'd0;
                    end else begin
                        w_p_vpos_n     = (w_diff < -STEP_S) ? r_p_vpos - STEP_L : r_target;
                        w_char_frame_n = 2'd1;
                    end
                end
                S_AIR: begin
                    if (w_sum >= {1'b0, r_target}) begin
                        w_p_vpos_n     = r_target;
                        w_state_n      = S_SURF;
                        w_landed_n     = 1'b1;
                        w_air_frames_n = w_cnt_inc;
                        w_char_frame_n = 2'd0;
                        w_vel_n        = 8'd0;
                        w_air_cnt_n    = 8'd0;
                    end else begin
                        w_p_vpos_n     = w_sum[9:0];
                        w_vel_n        = w_vel_nx;
                        w_air_cnt_n    = w_cnt_inc;
                        w_char_frame_n = 2'd2;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_p_vpos       <= START_L;
            r_char_frame   <= 2'd0;
            r_landed       <= 1'b0;
            r_air_frames   <= 8'd0;
            r_target       <= START_L;
            r_target_valid <= 1'b0;
            r_vel          <= 8'd0;
            r_air_cnt      <= 8'd0;
        end else begin
            r_state        <= w_state_n;
            r_p_vpos       <= w_p_vpos_n;
            r_char_frame   <= w_char_frame_n;
            r_landed       <= w_landed_n;
            r_air_frames   <= w_air_frames_n;
            r_target       <= w_target_n;
            r_target_valid <= w_target_valid_n;
            r_vel          <= w_vel_n;
            r_air_cnt      <= w_air_cnt_n;
        end
    end

    assign p_vpos     = r_p_vpos;
    assign char_frame = r_char_frame;
    assign airborne   = (r_state == S_AIR);
    assign landed     = r_landed;
    assign air_frames = r_air_frames;

endmodule
